// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus used by the fetch stage.
// master = fetch side (drives request), slave = memory side.
interface if_fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;

  modport master (output ImemReq, output ImemAddr, input ImemAck, input ImemData);
  modport slave  (input ImemReq, input ImemAddr, output ImemAck, output ImemData);
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, imem handshake, skid register and IF/ID pipeline register.
// Optional stall/flush counters are built only when FETCH_PERF_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | request outstanding at PC
// S_HOLD  | front end stalled, fetched instruction parked in skid
// S_DRAIN | redirect seen mid-request; waiting for ack to discard data
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    PCWr,
  input  logic                    IFIDWr,
  input  logic                    BranchTaken,
  input  logic [31:0]             BranchTarget,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             IFIDInstr,
  output logic [31:0]             IFIDPCPlus4,
  output logic                    IFIDValid,
  output logic [15:0]             StallCnt,
  output logic [15:0]             FlushCnt
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic        stall;

  assign stall    = ~PCWr | ~IFIDWr;
  assign pc_plus4 = pc + 32'd4;
  assign br_tgt   = BranchTarget & ALIGN_MASK;

  // The memory shares rst, so suppressing the request during reset is safe.
  assign imem.ImemReq  = ~rst & (state != S_HOLD);
  assign imem.ImemAddr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC & ALIGN_MASK;
      skid        <= '0;
      target      <= '0;
      IFIDInstr   <= NOP_INSTR;
      IFIDPCPlus4 <= '0;
      IFIDValid   <= 1'b0;
    end else if (BranchTaken) begin
      IFIDInstr <= NOP_INSTR;
      IFIDValid <= 1'b0;
      skid      <= '0;
      if (state == S_HOLD || imem.ImemAck) begin
        pc    <= br_tgt;
        state <= S_FETCH;
      end else begin
        target <= br_tgt;
        state  <= S_DRAIN;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (imem.ImemAck) begin
            if (!stall) begin
              IFIDInstr   <= imem.ImemData;
              IFIDPCPlus4 <= pc_plus4;
              IFIDValid   <= 1'b1;
              pc          <= pc_plus4;
            end else begin
              skid  <= imem.ImemData;
              state <= S_HOLD;
            end
          end else if (!stall) begin
            IFIDInstr <= NOP_INSTR;
            IFIDValid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            IFIDInstr   <= skid;
            IFIDPCPlus4 <= pc_plus4;
            IFIDValid   <= 1'b1;
            pc          <= pc_plus4;
            skid        <= '0;
            state       <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem.ImemAck) begin
            pc    <= target;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (BranchTaken && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed + randomized bench for if_fetch_stage against a transaction-level model
// of the front end (next PC, parked instruction, pending redirect).
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWr, IFIDWr, BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] IFIDInstr, IFIDPCPlus4;
  logic        IFIDValid;
  logic [15:0] StallCnt, FlushCnt;

  always #5 clk = ~clk;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .PCWr         (PCWr),
    .IFIDWr       (IFIDWr),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .imem         (bus),
    .IFIDInstr    (IFIDInstr),
    .IFIDPCPlus4  (IFIDPCPlus4),
    .IFIDValid    (IFIDValid),
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  bit [31:0]   m_pc, m_skid, m_tgt, m_instr, m_pc4;
  bit          m_valid, m_parked, m_redirect;
  int unsigned m_scnt, m_fcnt;
  // memory model
  int          mem_lat = 0;
  int          lat_cnt = 0;
  bit          rand_ack = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters();
`ifdef FETCH_PERF_EN
    chk("stall_cnt", {16'h0, StallCnt}, m_scnt);
    chk("flush_cnt", {16'h0, FlushCnt}, m_fcnt);
`else
    chk("stall_cnt_tied", {16'h0, StallCnt}, 32'h0);
    chk("flush_cnt_tied", {16'h0, FlushCnt}, 32'h0);
`endif
  endtask

  task automatic model_reset();
    m_pc = RST_PC & 32'hFFFF_FFFC; m_skid = 0; m_tgt = 0;
    m_instr = NOP; m_pc4 = 0; m_valid = 0;
    m_parked = 0; m_redirect = 0; m_scnt = 0; m_fcnt = 0;
    lat_cnt = 0;
  endtask

  task automatic rst_cycles(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      PCWr = $urandom_range(0, 1); IFIDWr = 1'b0; BranchTaken = 1'b1;
      BranchTarget = $urandom; bus.ImemAck = 1'b1; bus.ImemData = $urandom;
      #1;
      chk("req_in_reset", {31'h0, bus.ImemReq}, 32'h0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model_reset();
    chk("rst_instr", IFIDInstr, NOP);
    chk("rst_pc4", IFIDPCPlus4, 32'h0);
    chk("rst_valid", {31'h0, IFIDValid}, 32'h0);
    chk_counters();
  endtask

  task automatic cycle(input bit pcwr, input bit ifidwr, input bit br, input bit [31:0] tgt);
    bit        ack, stall, m_req, was_parked;
    bit [31:0] data;
    PCWr = pcwr; IFIDWr = ifidwr; BranchTaken = br; BranchTarget = tgt;
    m_req = !m_parked;
    if (!m_req)        ack = 1'b0;
    else if (rand_ack) ack = ($urandom_range(0, 2) == 0);
    else               ack = (lat_cnt >= mem_lat);
    data = ack ? mem_word(m_pc) : $urandom;
    bus.ImemAck = ack; bus.ImemData = data;
    #1;
    chk("imem_req", {31'h0, bus.ImemReq}, {31'h0, m_req});
    if (m_req) chk("imem_addr", bus.ImemAddr, m_pc);
    if (m_req) lat_cnt = ack ? 0 : lat_cnt + 1;

    stall = !pcwr || !ifidwr;
    was_parked = m_parked;
    if (br) begin
      m_instr = NOP; m_valid = 0; m_parked = 0;
      if (was_parked || ack) begin
        m_pc = tgt & 32'hFFFF_FFFC; m_redirect = 0;
      end else begin
        m_tgt = tgt & 32'hFFFF_FFFC; m_redirect = 1;
      end
    end else if (m_redirect) begin
      if (ack) begin m_pc = m_tgt; m_redirect = 0; end
    end else if (m_parked) begin
      if (!stall) begin
        m_instr = m_skid; m_pc4 = m_pc + 4; m_valid = 1;
        m_pc = m_pc + 4; m_parked = 0;
      end
    end else if (ack) begin
      if (!stall) begin
        m_instr = data; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end else begin
        m_skid = data; m_parked = 1;
      end
    end else if (!stall) begin
      m_instr = NOP; m_valid = 0;
    end
    if (stall && m_scnt < 32'hFFFF) m_scnt++;
    if (br && m_fcnt < 32'hFFFF) m_fcnt++;

    @(posedge clk); #1;
    chk("ifid_valid", {31'h0, IFIDValid}, {31'h0, m_valid});
    chk("ifid_instr", IFIDInstr, m_instr);
    if (m_valid) chk("ifid_pc4", IFIDPCPlus4, m_pc4);
    chk_counters();
  endtask

  initial begin
    rst = 1'b1; PCWr = 1'b1; IFIDWr = 1'b1; BranchTaken = 1'b0;
    BranchTarget = '0; bus.ImemAck = 1'b0; bus.ImemData = '0;
    model_reset();
    @(posedge clk); #1;
    rst_cycles(2);

    // zero-wait streaming from reset
    mem_lat = 0;
    repeat (3) cycle(1, 1, 0, 0);

    // one-cycle load-use stall at 0x10
    for (int i = 0; i < 20 && m_pc != 32'h10; i++) cycle(1, 1, 0, 0);
    chk("reach_0x10", bus.ImemAddr, 32'h10);
    cycle(0, 0, 0, 0);
    repeat (3) cycle(1, 1, 0, 0);

    // 3-cycle latency memory, no stalls
    mem_lat = 2;
    for (int i = 0; i < 40 && !(m_pc == 32'h20 && lat_cnt == 0); i++) cycle(1, 1, 0, 0);
    chk("reach_0x20", bus.ImemAddr, 32'h20);
    // redirect while 0x20 still has two cycles to go
    cycle(1, 1, 1, 32'h100);
    repeat (7) cycle(1, 1, 0, 0);

    // stall + redirect while parked
    mem_lat = 0;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 32'h200);
    repeat (3) cycle(1, 1, 0, 0);

    // two redirects while draining
    mem_lat = 3;
    cycle(1, 1, 1, 32'h300);
    cycle(1, 1, 1, 32'h402);
    repeat (6) cycle(1, 1, 0, 0);

    // PC wrap, with low target bits set
    mem_lat = 0;
    cycle(1, 1, 1, 32'hFFFF_FFFF);
    repeat (3) cycle(1, 1, 0, 0);

    // reset mid-request and mid-hold
    mem_lat = 3;
    repeat (2) cycle(1, 1, 0, 0);
    rst_cycles(1);
    repeat (2) cycle(1, 1, 0, 0);
    mem_lat = 0;
    cycle(1, 0, 0, 0);
    rst_cycles(1);
    repeat (2) cycle(1, 1, 0, 0);

    // randomized traffic
    rand_ack = 1;
    repeat (600)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
            $urandom_range(0, 9) == 0, $urandom);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
